// File: rtl/kgp_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP-RISC core.
// Decides when each datapath stage fires over a shared memory port with a ready handshake.
module kgp_multicycle_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             alu_en,
    output logic             reg_write,
    output logic             pc_write,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_ALU    = 2'd0,
        C_BRANCH = 2'd1,
        C_LOAD   = 2'd2,
        C_STORE  = 2'd3
    } cls_t;

    // Last wait-counter value at which a still-missing mem_ready becomes a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d;
    logic [7:0]        wait_q, wait_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              retire;
    logic              boundary;

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        wait_d       = wait_q;
        error_d      = error_q;
        count_d      = count_q;
        retire       = 1'b0;
        boundary     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        alu_en       = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode)
                    6'b000001, 6'b000010, 6'b000011,
                    6'b100100, 6'b100101: cls_d = C_ALU;
                    6'b000100, 6'b000101, 6'b000110: cls_d = C_BRANCH;
                    6'b100011: cls_d = C_LOAD;
                    6'b101011: cls_d = C_STORE;
                    6'b111111: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (cls_q)
                    C_BRANCH: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                        wait_d  = 8'd0;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                boundary  = 1'b1;
            end
            S_HALT: ;
            default: begin
                // Covers IDLE and the unused encoding 7.
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
        endcase

        if (boundary) begin
            state_d = run ? S_FETCH : S_IDLE;
            wait_d  = 8'd0;
        end
        if (retire) count_d = count_q + CNT_W'(1);

        // Strobes are held off during reset even though state is not yet IDLE.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            alu_en       = 1'b0;
            reg_write    = 1'b0;
            pc_write     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cls_q   <= C_ALU;
            wait_q  <= 8'd0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign halted      = (state_q == S_HALT);
    assign error       = error_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_kgp_multicycle_sequencer.sv
// Directed bench for kgp_multicycle_sequencer with a narrow counter and short memory timeout.
module tb_kgp_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, alu_en, reg_write, pc_write;
    logic       halted, error;
    logic [2:0] state;
    logic [1:0] instr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kgp_multicycle_sequencer #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .alu_en(alu_en), .reg_write(reg_write), .pc_write(pc_write),
        .halted(halted), .error(error), .state(state), .instr_count(instr_count)
    );

    // Strobe vector order: {mem_req, mem_we, mem_addr_sel, ir_write, alu_en, reg_write, pc_write}
    typedef struct {
        logic       r;
        logic       ru;
        logic [5:0] op;
        logic       rd;
        logic [2:0] st;
        logic [6:0] sb;
        logic       h;
        logic       e;
        logic [1:0] c;
    } vec_t;

    vec_t tbl[$];

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] FIR  = 7'b1001000;
    localparam logic [6:0] FW   = 7'b1000000;
    localparam logic [6:0] EX   = 7'b0000100;
    localparam logic [6:0] EXB  = 7'b0000101;
    localparam logic [6:0] WB   = 7'b0000011;
    localparam logic [6:0] ML   = 7'b1010000;
    localparam logic [6:0] MS   = 7'b1110000;
    localparam logic [6:0] MSR  = 7'b1110001;

    task automatic add(input logic r, input logic ru, input logic [5:0] op, input logic rd,
                       input logic [2:0] st, input logic [6:0] sb, input logic h,
                       input logic e, input logic [1:0] c);
        vec_t v;
        v.r = r; v.ru = ru; v.op = op; v.rd = rd;
        v.st = st; v.sb = sb; v.h = h; v.e = e; v.c = c;
        tbl.push_back(v);
    endtask

    function automatic logic [14:0] observed();
        return {state, mem_req, mem_we, mem_addr_sel, ir_write, alu_en, reg_write, pc_write,
                halted, error, instr_count};
    endfunction

    initial begin
        logic [14:0] got, exp;
        int pw_cnt, rw_cnt;

        // ALU instructions back-to-back
        add(1, 1, 6'h01, 1, 0, NONE, 0, 0, 0);
        add(0, 1, 6'h01, 1, 0, NONE, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 6'h01, 1, 1, FIR,  0, 0, 2'(k));
            add(0, 1, 6'h01, 1, 2, NONE, 0, 0, 2'(k));
            add(0, 1, 6'h01, 1, 3, EX,   0, 0, 2'(k));
            add(0, 1, 6'h01, 1, 5, WB,   0, 0, 2'(k));
        end
        // Branches: counter wraps 3 -> 0, then run drops during EXEC
        add(0, 1, 6'h04, 1, 1, FIR,  0, 0, 3);
        add(0, 1, 6'h04, 1, 2, NONE, 0, 0, 3);
        add(0, 1, 6'h04, 1, 3, EXB,  0, 0, 3);
        add(0, 1, 6'h04, 1, 1, FIR,  0, 0, 0);
        add(0, 1, 6'h04, 1, 2, NONE, 0, 0, 0);
        add(0, 0, 6'h04, 1, 3, EXB,  0, 0, 0);
        add(0, 0, 6'h04, 1, 0, NONE, 0, 0, 1);
        add(0, 0, 6'h04, 1, 0, NONE, 0, 0, 1);
        // Load with three wait cycles in MEM (last one lands on the limit)
        add(0, 1, 6'h23, 1, 0, NONE, 0, 0, 1);
        add(0, 1, 6'h23, 1, 1, FIR,  0, 0, 1);
        add(0, 1, 6'h23, 1, 2, NONE, 0, 0, 1);
        add(0, 1, 6'h23, 1, 3, EX,   0, 0, 1);
        add(0, 1, 6'h23, 0, 4, ML,   0, 0, 1);
        add(0, 1, 6'h23, 0, 4, ML,   0, 0, 1);
        add(0, 1, 6'h23, 0, 4, ML,   0, 0, 1);
        add(0, 1, 6'h23, 1, 4, ML,   0, 0, 1);
        add(0, 1, 6'h23, 1, 5, WB,   0, 0, 1);
        // Store with one wait cycle
        add(0, 1, 6'h2B, 1, 1, FIR,  0, 0, 2);
        add(0, 1, 6'h2B, 1, 2, NONE, 0, 0, 2);
        add(0, 1, 6'h2B, 1, 3, EX,   0, 0, 2);
        add(0, 1, 6'h2B, 0, 4, MS,   0, 0, 2);
        add(0, 1, 6'h2B, 1, 4, MSR,  0, 0, 2);
        // Illegal opcode -> HALT with error, count unchanged, reset clears
        add(0, 1, 6'h0F, 1, 1, FIR,  0, 0, 3);
        add(0, 1, 6'h0F, 1, 2, NONE, 0, 0, 3);
        add(0, 1, 6'h0F, 1, 6, NONE, 1, 1, 3);
        add(0, 1, 6'h0F, 1, 6, NONE, 1, 1, 3);
        add(1, 1, 6'h0F, 1, 6, NONE, 1, 1, 3);
        add(0, 0, 6'h0F, 1, 0, NONE, 0, 0, 0);
        // Fetch timeout after four waiting cycles
        add(0, 1, 6'h01, 0, 0, NONE, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 6'h01, 0, 1, FW, 0, 0, 0);
        add(0, 1, 6'h01, 0, 6, NONE, 1, 1, 0);
        add(1, 1, 6'h01, 0, 6, NONE, 1, 1, 0);
        // Ready on the limit cycle succeeds; halt instruction retires without error
        add(0, 1, 6'h3F, 0, 0, NONE, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 6'h3F, 0, 1, FW, 0, 0, 0);
        add(0, 1, 6'h3F, 1, 1, FIR,  0, 0, 0);
        add(0, 1, 6'h3F, 1, 2, NONE, 0, 0, 0);
        add(0, 1, 6'h3F, 1, 6, NONE, 1, 0, 1);
        // Reset in the middle of a MEM access
        add(1, 1, 6'h23, 1, 6, NONE, 1, 0, 1);
        add(0, 1, 6'h23, 1, 0, NONE, 0, 0, 0);
        add(0, 1, 6'h23, 1, 1, FIR,  0, 0, 0);
        add(0, 1, 6'h23, 1, 2, NONE, 0, 0, 0);
        add(0, 1, 6'h23, 1, 3, EX,   0, 0, 0);
        add(0, 1, 6'h23, 0, 4, ML,   0, 0, 0);
        add(1, 1, 6'h23, 0, 4, NONE, 0, 0, 0);
        add(0, 0, 6'h23, 0, 0, NONE, 0, 0, 0);

        rst = 1'b1; run = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].r; run = tbl[i].ru; opcode = tbl[i].op; mem_ready = tbl[i].rd;
            #1;
            got = observed();
            exp = {tbl[i].st, tbl[i].sb, tbl[i].h, tbl[i].e, tbl[i].c};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL vec%0d {st,strb,hlt,err,cnt}: got %b want %b", i, got, exp);
            end
        end

        // Hand-written: ALU op 100101 from reset, strobe pulses over four instructions
        @(negedge clk);
        rst = 1'b1; run = 1'b1; opcode = 6'h25; mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pw_cnt = 0; rw_cnt = 0;
        for (int k = 0; k < 17; k++) begin
            #1;
            if (pc_write)  pw_cnt++;
            if (reg_write) rw_cnt++;
            @(negedge clk);
        end
        checks++;
        if (pw_cnt != 4) begin
            failures++;
            $display("FAIL alu25_pc_write_pulses: got %0d want 4", pw_cnt);
        end
        checks++;
        if (rw_cnt != 4) begin
            failures++;
            $display("FAIL alu25_reg_write_pulses: got %0d want 4", rw_cnt);
        end
        #1;
        checks++;
        if (instr_count !== 2'd0 || state !== 3'd1) begin
            failures++;
            $display("FAIL alu25_wrap_state: got cnt=%0d st=%0d want cnt=0 st=1", instr_count, state);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kgp_multicycle_sequencer.md
# kgp_multicycle_sequencer

Multi-cycle control sequencer for the KGP-RISC core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared instruction/data memory port with a ready handshake. It drives the per-stage enables (IR, PC, register file, ALU) and the memory request/select lines, and counts retired instructions. It sits beside the combinational opcode decoder; the decoder still supplies the datapath mux selects, and this block decides *when* each stage fires.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready per access (legal 1..255)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- opcode  in  6  opcode field of the instruction register
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store), valid only with mem_req
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_write  out  1  load instruction register
- alu_en  out  1  ALU operand/result capture enable
- reg_write  out  1  register-file write enable
- pc_write  out  1  PC update (PC+1 or branch target chosen by datapath)
- halted  out  1  in HALT state
- error  out  1  sticky: illegal opcode or memory timeout
- state  out  3  current state encoding (debug)
- instr_count  out  CNT_W  retired instructions

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 is unreachable and is treated as IDLE.
- IDLE: all strobes 0. run=1 -> FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. On mem_ready: ir_write=1 that cycle -> DECODE.
- DECODE: one cycle, no strobes.
  - opcode 111111 -> HALT (halt instruction; retires, count+1).
  - Legal opcodes are 000001-000110, 100011, 101011, 100100, 100101. Any legal opcode -> EXEC.
  - Any other opcode -> HALT with error=1, no retire.
- EXEC: alu_en=1 for one cycle.
  - Branch (000100/000101/000110): pc_write=1, retire -> boundary.
  - Load (100011) / store (101011): -> MEM.
  - ALU ops (000001-000011, 100100, 100101): -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store only.
  - On mem_ready: load -> WB.
  - On mem_ready: store asserts pc_write=1, retires -> boundary.
- WB: reg_write=1, pc_write=1 for one cycle, retire -> boundary.
- Boundary (next state after a retire): run=1 -> FETCH; run=0 -> IDLE. A run drop mid-instruction never aborts the instruction.
- HALT: halted=1, all other strobes 0. Exit only via rst.
- Retire: instr_count += 1 on the retire edge. Wraps from 2^CNT_W-1 to 0, no flag.
- Timeout: an 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0. When it reaches MEM_TIMEOUT with mem_ready still 0 -> HALT, error=1, mem_req dropped next cycle. mem_ready on the same cycle as the limit is a success.
- mem_ready outside FETCH/MEM is ignored.

## Timing
- Strobes are combinational from registered state, plus mem_ready for ir_write/pc_write in FETCH/MEM. No strobe asserts while rst=1.
- Reset: state=IDLE, instr_count=0, error=0, wait counter=0. All outputs 0 on the cycle after rst is sampled, including mid-access.
- Latency with zero memory wait (cycles per instruction):
  - ALU: 4 (F, D, E, W)
  - load: 5 (F, D, E, M, W)
  - store: 4 (F, D, E, M)
  - branch: 3 (F, D, E)
- Each cycle of mem_ready=0 adds one cycle per access.
- IDLE -> FETCH: the first mem_req appears the cycle after run is sampled high.
- pc_write and reg_write never assert more than once per instruction. ir_write asserts exactly once per fetch.

## Test plan
- Reset, run=1, opcode=000001, mem_ready=1 constant -> states 1,2,3,5 repeating. reg_write and pc_write pulse every 4th cycle. instr_count=3 after 12 cycles.
- Load 100011, mem_ready low 3 cycles in MEM -> mem_req/mem_addr_sel=1 for 4 MEM cycles, then a WB pulse. Load latency is 8 cycles.
- Store 101011 -> mem_we=1 only in MEM. reg_write never 1. pc_write on the mem_ready cycle.
- opcode 001111 -> DECODE then HALT; error=1, halted=1, instr_count unchanged. rst=1 one cycle -> IDLE, error=0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 waiting cycles, error=1. Repeat with mem_ready on the 4th cycle -> DECODE.
- CNT_W=2, branches back-to-back -> count 3 -> 0 wrap. Drop run during EXEC -> instruction retires, then IDLE. Assert rst mid-MEM -> next cycle mem_req=0, state=0.
